input_credit_buffer: RTL and testbench

// Router input-port buffer; the credit-issuing end of the link whose credit_en pulses the flow control unit consumes.

---
 rtl/noc_pkg.sv | 13 +
 rtl/input_credit_buffer_if.sv | 25 ++
 rtl/noc_sync_fifo.sv | 38 +++
 rtl/input_credit_buffer.sv | 49 ++++
 tb/tb_input_credit_buffer.sv | 131 +++++++++++++
 5 files changed

// File: rtl/noc_pkg.sv
// noc_pkg: router port addressing constants shared by the input-port blocks
package noc_pkg;
  localparam int PORT_ADDR_W = 3;
  localparam int DEFAULT_FLIT_W = 32;
  localparam logic [PORT_ADDR_W-1:0] PORT_NORTH = 3'd0;
  localparam logic [PORT_ADDR_W-1:0] PORT_SOUTH = 3'd1;
  localparam logic [PORT_ADDR_W-1:0] PORT_EAST  = 3'd2;
  localparam logic [PORT_ADDR_W-1:0] PORT_WEST  = 3'd3;
  localparam logic [PORT_ADDR_W-1:0] PORT_LOCAL = 3'd4;
  function automatic logic is_legal_port(input logic [PORT_ADDR_W-1:0] addr);
    return addr <= PORT_LOCAL;
  endfunction
endpackage

// File: rtl/input_credit_buffer_if.sv
// input_credit_buffer_if: upstream link, switch request and status signals of one input port
interface input_credit_buffer_if import noc_pkg::*; #(
  parameter int FLIT_W = DEFAULT_FLIT_W,
  parameter int DEPTH = 4
) ();
  localparam int CNT_W = $clog2(DEPTH + 1);
  logic [FLIT_W-1:0]      flit_i;
  logic                   flit_valid_i;
  logic                   credit_o;
  logic                   req_valid_o;
  logic [PORT_ADDR_W-1:0] req_port_addr_o;
  logic [FLIT_W-1:0]      flit_o;
  logic                   grant_i;
  logic [CNT_W-1:0]       count_o;
  logic                   overflow_err_o;
  logic                   bad_addr_err_o;
  modport master (
    output flit_i, flit_valid_i, grant_i,
    input  credit_o, req_valid_o, req_port_addr_o, flit_o, count_o, overflow_err_o, bad_addr_err_o
  );
  modport slave (
    input  flit_i, flit_valid_i, grant_i,
    output credit_o, req_valid_o, req_port_addr_o, flit_o, count_o, overflow_err_o, bad_addr_err_o
  );
endinterface

// File: rtl/noc_sync_fifo.sv
// noc_sync_fifo: power-of-two synchronous FIFO with head presented from storage, zero when empty
module noc_sync_fifo #(
  parameter int FLIT_W = 32,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [FLIT_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [FLIT_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);
  logic [FLIT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  // storage write; when full with a simultaneous read the slot being freed is reused
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr] <= wr_data;
  // pointers wrap naturally at DEPTH; count tracks occupancy
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(wr_en) - CNT_W'(rd_en);
    end
  assign full    = count == CNT_W'(DEPTH);
  assign empty   = count == '0;
  assign rd_data = empty ? '0 : mem[rd_ptr];
endmodule

// File: rtl/input_credit_buffer.sv
// input_credit_buffer: router input-port FIFO that returns one upstream credit per freed slot
module input_credit_buffer import noc_pkg::*; #(
  parameter int FLIT_W = DEFAULT_FLIT_W,
  parameter int DEPTH = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  input_credit_buffer_if.slave bus
);
  localparam int PEND_W = $clog2(DEPTH + 2);
  logic              full;
  logic              empty;
  logic              pop;
  logic              legal;
  logic              push;
  logic              discard;
  logic [PEND_W-1:0] pend;
  assign pop     = bus.grant_i & ~empty;
  assign legal   = is_legal_port(bus.flit_i[PORT_ADDR_W-1:0]);
  assign push    = bus.flit_valid_i & legal & (~full | pop);
  assign discard = bus.flit_valid_i & ~legal;
  noc_sync_fifo #(.FLIT_W(FLIT_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_data (bus.flit_i),
    .rd_en   (pop),
    .rd_data (bus.flit_o),
    .full    (full),
    .empty   (empty),
    .count   (bus.count_o)
  );
  assign bus.req_valid_o     = ~empty;
  assign bus.req_port_addr_o = bus.flit_o[PORT_ADDR_W-1:0];
  assign bus.credit_o        = pend != '0;
  // pending credits: pops and illegal discards add, each issued pulse drains one
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pend <= '0;
    else pend <= pend + PEND_W'(pop) + PEND_W'(discard) - PEND_W'(bus.credit_o);
  // sticky error flags, cleared only by reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.overflow_err_o <= 1'b0;
      bus.bad_addr_err_o <= 1'b0;
    end else begin
      if (bus.flit_valid_i & legal & full & ~pop) bus.overflow_err_o <= 1'b1;
      if (discard) bus.bad_addr_err_o <= 1'b1;
    end
endmodule

// File: tb/tb_input_credit_buffer.sv
// tb_input_credit_buffer: scoreboard bench for the input credit buffer
module tb_input_credit_buffer;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] q[$];
  int m_pend;
  int up_cred;
  logic m_ovf;
  logic m_bad;
  input_credit_buffer_if #(.FLIT_W(32), .DEPTH(DEPTH)) bus ();
  input_credit_buffer #(.FLIT_W(32), .DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask
  function automatic logic [31:0] mk(input int addr);
    logic [31:0] r;
    r = $urandom;
    r[2:0] = 3'(addr);
    return r;
  endfunction
  task automatic cycle(input logic v, input logic [31:0] f, input logic g);
    int n;
    logic pop, legal, acc;
    logic [31:0] head;
    bus.flit_valid_i = v;
    bus.flit_i = f;
    bus.grant_i = g;
    @(negedge clk);
    n = q.size();
    head = n != 0 ? q[0] : 32'h0;
    pop = g && n != 0;
    legal = f[2:0] <= 3'd4;
    acc = v && legal && (n < DEPTH || pop);
    check("count", 64'(bus.count_o), 64'(n));
    check("req_valid", 64'(bus.req_valid_o), 64'(n != 0));
    check("port_addr", 64'(bus.req_port_addr_o), 64'(head[2:0]));
    check("credit", 64'(bus.credit_o), 64'(m_pend != 0));
    check("overflow", 64'(bus.overflow_err_o), 64'(m_ovf));
    check("bad_addr", 64'(bus.bad_addr_err_o), 64'(m_bad));
    if (pop) check("pop_flit", 64'(bus.flit_o), 64'(q.pop_front()));
    else check("head", 64'(bus.flit_o), 64'(head));
    if (bus.credit_o) up_cred++;
    if (v) up_cred--;
    @(posedge clk);
    #1;
    if (acc) q.push_back(f);
    m_pend = m_pend + int'(pop) + int'(v && !legal) - int'(m_pend != 0);
    if (v && legal && n == DEPTH && !pop) m_ovf = 1'b1;
    if (v && !legal) m_bad = 1'b1;
  endtask
  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cycle(1'b0, 32'h0, 1'b0);
  endtask
  task automatic drain(input int k);
    for (int i = 0; i < k; i++) cycle(1'b0, 32'h0, 1'b1);
  endtask
  task automatic do_reset();
    bus.flit_valid_i = 1'b0;
    bus.flit_i = 32'h0;
    bus.grant_i = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_count", 64'(bus.count_o), 64'd0);
    check("rst_req_valid", 64'(bus.req_valid_o), 64'd0);
    check("rst_flit", 64'(bus.flit_o), 64'd0);
    check("rst_port_addr", 64'(bus.req_port_addr_o), 64'd0);
    check("rst_credit", 64'(bus.credit_o), 64'd0);
    check("rst_overflow", 64'(bus.overflow_err_o), 64'd0);
    check("rst_bad_addr", 64'(bus.bad_addr_err_o), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    q.delete();
    m_pend = 0;
    m_ovf = 1'b0;
    m_bad = 1'b0;
    up_cred = DEPTH;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, mk(i), 1'b0);
    cycle(1'b1, mk(7), 1'b1);
    check("pre_rst_count", 64'(bus.count_o), 64'd3);
    do_reset();
    idle(3);
    cycle(1'b1, mk(2), 1'b0);
    cycle(1'b0, 32'h0, 1'b1);
    idle(3);
    for (int i = 0; i < 4; i++) cycle(1'b1, mk(i), 1'b0);
    cycle(1'b1, mk(4), 1'b0);
    idle(2);
    cycle(1'b1, mk(1), 1'b1);
    idle(2);
    drain(5);
    idle(3);
    do_reset();
    cycle(1'b1, mk(6), 1'b0);
    idle(3);
    do_reset();
    for (int i = 0; i < 200; i++) begin
      logic v, g;
      v = (up_cred > 0) && ($urandom_range(0, 1) == 1);
      g = $urandom_range(0, 2) != 0;
      cycle(v, mk(int'($urandom_range(0, 7))), g);
    end
    drain(DEPTH + 2);
    idle(DEPTH + 3);
    check("credit_total_rand", 64'(up_cred), 64'(DEPTH));
    do_reset();
    cycle(1'b1, mk(3), 1'b0);
    cycle(1'b1, mk(0), 1'b0);
    cycle(1'b1, mk(5), 1'b1);
    idle(4);
    drain(2);
    idle(4);
    check("credit_total", 64'(up_cred), 64'(DEPTH));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
